// File: rtl/thread_scheduler_pkg.sv
// thread_scheduler_pkg: shared widths and per-thread state encoding for the thread scheduler
package thread_scheduler_pkg;
    localparam int ADDRESS_WIDTH = 32;
    localparam int BITS_THREADS = 3;
    localparam int NTHREADS = 2 ** BITS_THREADS;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;
endpackage

// File: rtl/thread_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector, first set mask bit strictly after last
module rr_pick #(
    parameter int W = 3,
    parameter int N = 2 ** W
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] last,
    output logic [W-1:0] tid,
    output logic         found
);
    logic [W-1:0] idx;
    // Scan from farthest to nearest so the nearest candidate overwrites; i == N wraps back to last itself
    always_comb begin
        tid = last;
        found = 1'b0;
        idx = last;
        for (int i = N; i >= 1; i--) begin
            idx = last + W'(i);
            if (mask[idx]) begin
                tid = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin fetch issue across hardware threads with per-thread PC table
module thread_scheduler #(
    parameter int ADDRESS_WIDTH = thread_scheduler_pkg::ADDRESS_WIDTH,
    parameter int BITS_THREADS = thread_scheduler_pkg::BITS_THREADS,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         stall_i,
    input  logic                         start_i,
    input  logic [BITS_THREADS-1:0]      start_tid_i,
    input  logic [ADDRESS_WIDTH-1:0]     start_pc_i,
    input  logic                         halt_i,
    input  logic [BITS_THREADS-1:0]      halt_tid_i,
    input  logic                         redir_i,
    input  logic [BITS_THREADS-1:0]      redir_tid_i,
    input  logic [ADDRESS_WIDTH-1:0]     redir_pc_i,
    output logic [ADDRESS_WIDTH-1:0]     pc_f_o,
    output logic [ADDRESS_WIDTH-1:0]     pc_plus4_f_o,
    output logic [BITS_THREADS-1:0]      tid_f_o,
    output logic                         valid_f_o,
    output logic [2**BITS_THREADS-1:0]   active_o
);
    import thread_scheduler_pkg::*;
    localparam int NT = 2 ** BITS_THREADS;
    logic [NT-1:0]            run;
    logic [ADDRESS_WIDTH-1:0] pc_tab [NT];
    logic [BITS_THREADS-1:0]  last;
    logic [BITS_THREADS-1:0]  sel;
    logic                     found;
    logic                     issue;
    logic [ADDRESS_WIDTH-1:0] sel_pc;
    rr_pick #(.W(BITS_THREADS)) u_pick (
        .mask  (run),
        .last  (last),
        .tid   (sel),
        .found (found)
    );
    assign issue = found && !stall_i;
    // A redirect landing on the thread being issued bypasses the stale table entry
    assign sel_pc = (redir_i && redir_tid_i == sel) ? redir_pc_i : pc_tab[sel];
    assign active_o = run;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NT; i++) begin
                run[i] <= (i == 0) ? RUN : IDLE;
                pc_tab[i] <= (i == 0) ? RESET_PC : '0;
            end
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (halt_i && halt_tid_i == BITS_THREADS'(i))
                    run[i] <= IDLE;
                else if (start_i && start_tid_i == BITS_THREADS'(i))
                    run[i] <= RUN;
                if (start_i && start_tid_i == BITS_THREADS'(i))
                    pc_tab[i] <= start_pc_i;
                else if (issue && sel == BITS_THREADS'(i))
                    pc_tab[i] <= sel_pc + ADDRESS_WIDTH'(4);
                else if (redir_i && redir_tid_i == BITS_THREADS'(i) && run[i] == RUN)
                    pc_tab[i] <= redir_pc_i;
            end
        end
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_f_o <= '0;
            pc_plus4_f_o <= '0;
            tid_f_o <= '0;
            valid_f_o <= 1'b0;
            last <= '1;
        end else if (!stall_i) begin
            valid_f_o <= found;
            if (found) begin
                pc_f_o <= sel_pc;
                pc_plus4_f_o <= sel_pc + ADDRESS_WIDTH'(4);
                tid_f_o <= sel;
                last <= sel;
            end
        end
    end
endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed self-checking bench for thread_scheduler
module tb_thread_scheduler;
    logic        clk;
    logic        clr_n;
    logic        stall_i;
    logic        start_i;
    logic [2:0]  start_tid_i;
    logic [31:0] start_pc_i;
    logic        halt_i;
    logic [2:0]  halt_tid_i;
    logic        redir_i;
    logic [2:0]  redir_tid_i;
    logic [31:0] redir_pc_i;
    logic [31:0] pc_f_o;
    logic [31:0] pc_plus4_f_o;
    logic [2:0]  tid_f_o;
    logic        valid_f_o;
    logic [7:0]  active_o;
    int checks = 0;
    int failures = 0;

    thread_scheduler dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .stall_i      (stall_i),
        .start_i      (start_i),
        .start_tid_i  (start_tid_i),
        .start_pc_i   (start_pc_i),
        .halt_i       (halt_i),
        .halt_tid_i   (halt_tid_i),
        .redir_i      (redir_i),
        .redir_tid_i  (redir_tid_i),
        .redir_pc_i   (redir_pc_i),
        .pc_f_o       (pc_f_o),
        .pc_plus4_f_o (pc_plus4_f_o),
        .tid_f_o      (tid_f_o),
        .valid_f_o    (valid_f_o),
        .active_o     (active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        stall_i = 0; start_i = 0; halt_i = 0; redir_i = 0;
        start_tid_i = 0; start_pc_i = 0; halt_tid_i = 0; redir_tid_i = 0; redir_pc_i = 0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        stall_i = 0; start_i = 0; halt_i = 0; redir_i = 0;
        start_tid_i = 0; start_pc_i = 0; halt_tid_i = 0; redir_tid_i = 0; redir_pc_i = 0;
        @(negedge clk);
        checks++;
        if (pc_f_o !== 32'h0 || pc_plus4_f_o !== 32'h0 || tid_f_o !== 3'd0 || valid_f_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got pc=%h p4=%h tid=%0d v=%b exp 0/0/0/0", pc_f_o, pc_plus4_f_o, tid_f_o, valid_f_o);
        end
        checks++;
        if (active_o !== 8'h01) begin
            failures++;
            $display("FAIL reset_active got=%h exp=01", active_o);
        end
        clr_n = 1'b1;
    endtask

    task automatic test_single_thread();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (valid_f_o !== 1'b1 || tid_f_o !== 3'd0 || pc_f_o !== 32'(4 * k) || pc_plus4_f_o !== 32'(4 * k + 4)) begin
                failures++;
                $display("FAIL single_issue%0d got v=%b tid=%0d pc=%h p4=%h exp 1/0/%h/%h", k, valid_f_o, tid_f_o, pc_f_o, pc_plus4_f_o, 4 * k, 4 * k + 4);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  et [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
        logic [31:0] ep [7] = '{32'h0, 32'h100, 32'h200, 32'h4, 32'h104, 32'h204, 32'h8};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            start_i = (k < 2);
            start_tid_i = 3'(k + 1);
            start_pc_i = (k == 0) ? 32'h100 : 32'h200;
            step();
            start_i = 1'b0;
            checks++;
            if (valid_f_o !== 1'b1 || tid_f_o !== et[k] || pc_f_o !== ep[k]) begin
                failures++;
                $display("FAIL rr_issue%0d got v=%b tid=%0d pc=%h exp 1/%0d/%h", k, valid_f_o, tid_f_o, pc_f_o, et[k], ep[k]);
            end
        end
        checks++;
        if (active_o !== 8'h07) begin
            failures++;
            $display("FAIL rr_active got=%h exp=07", active_o);
        end
    endtask

    task automatic test_stall();
        logic [2:0]  et [4] = '{3'd1, 3'd2, 3'd4, 3'd0};
        logic [31:0] ep [4] = '{32'h108, 32'h208, 32'h40, 32'hC};
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_i = (k == 0);
            start_tid_i = 3'd4;
            start_pc_i = 32'h40;
            step();
            start_i = 1'b0;
            checks++;
            if (valid_f_o !== 1'b1 || tid_f_o !== 3'd0 || pc_f_o !== 32'h8 || pc_plus4_f_o !== 32'hC) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b tid=%0d pc=%h p4=%h exp 1/0/8/c", k, valid_f_o, tid_f_o, pc_f_o, pc_plus4_f_o);
            end
        end
        stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (valid_f_o !== 1'b1 || tid_f_o !== et[k] || pc_f_o !== ep[k]) begin
                failures++;
                $display("FAIL stall_resume%0d got v=%b tid=%0d pc=%h exp 1/%0d/%h", k, valid_f_o, tid_f_o, pc_f_o, et[k], ep[k]);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        start_i = 1'b1; start_tid_i = 3'd1; start_pc_i = 32'h100;
        step();
        start_i = 1'b0;
        redir_i = 1'b1; redir_tid_i = 3'd1; redir_pc_i = 32'h400;
        step();
        redir_i = 1'b0;
        checks++;
        if (tid_f_o !== 3'd1 || pc_f_o !== 32'h400 || pc_plus4_f_o !== 32'h404) begin
            failures++;
            $display("FAIL redir_bypass got tid=%0d pc=%h p4=%h exp 1/400/404", tid_f_o, pc_f_o, pc_plus4_f_o);
        end
        step();
        redir_i = 1'b1; redir_tid_i = 3'd0; redir_pc_i = 32'h800;
        step();
        redir_i = 1'b0;
        checks++;
        if (tid_f_o !== 3'd1 || pc_f_o !== 32'h404) begin
            failures++;
            $display("FAIL redir_next got tid=%0d pc=%h exp 1/404", tid_f_o, pc_f_o);
        end
        step();
        checks++;
        if (tid_f_o !== 3'd0 || pc_f_o !== 32'h800) begin
            failures++;
            $display("FAIL redir_table got tid=%0d pc=%h exp 0/800", tid_f_o, pc_f_o);
        end
    endtask

    task automatic test_halt_start();
        do_reset();
        halt_i = 1'b1; halt_tid_i = 3'd0;
        step();
        halt_i = 1'b0;
        checks++;
        if (valid_f_o !== 1'b1 || tid_f_o !== 3'd0 || pc_f_o !== 32'h0) begin
            failures++;
            $display("FAIL halt_last_issue got v=%b tid=%0d pc=%h exp 1/0/0", valid_f_o, tid_f_o, pc_f_o);
        end
        step();
        checks++;
        if (valid_f_o !== 1'b0 || active_o !== 8'h00 || pc_f_o !== 32'h0 || tid_f_o !== 3'd0) begin
            failures++;
            $display("FAIL halt_idle got v=%b act=%h pc=%h tid=%0d exp 0/00/0/0", valid_f_o, active_o, pc_f_o, tid_f_o);
        end
        start_i = 1'b1; start_tid_i = 3'd5; start_pc_i = 32'h80;
        step();
        start_i = 1'b0;
        checks++;
        if (valid_f_o !== 1'b0) begin
            failures++;
            $display("FAIL start_latency got v=%b exp 0", valid_f_o);
        end
        step();
        checks++;
        if (valid_f_o !== 1'b1 || tid_f_o !== 3'd5 || pc_f_o !== 32'h80) begin
            failures++;
            $display("FAIL start_issue got v=%b tid=%0d pc=%h exp 1/5/80", valid_f_o, tid_f_o, pc_f_o);
        end
        step();
        checks++;
        if (tid_f_o !== 3'd5 || pc_f_o !== 32'h84) begin
            failures++;
            $display("FAIL start_advance got tid=%0d pc=%h exp 5/84", tid_f_o, pc_f_o);
        end
    endtask

    task automatic test_same_edge();
        start_i = 1'b1; start_tid_i = 3'd3; start_pc_i = 32'h300;
        halt_i = 1'b1; halt_tid_i = 3'd3;
        step();
        start_i = 1'b0; halt_i = 1'b0;
        checks++;
        if (active_o !== 8'h20 || tid_f_o !== 3'd5 || pc_f_o !== 32'h88) begin
            failures++;
            $display("FAIL start_halt_same got act=%h tid=%0d pc=%h exp 20/5/88", active_o, tid_f_o, pc_f_o);
        end
        step();
        checks++;
        if (tid_f_o !== 3'd5 || pc_f_o !== 32'h8C) begin
            failures++;
            $display("FAIL start_halt_excluded got tid=%0d pc=%h exp 5/8c", tid_f_o, pc_f_o);
        end
    endtask

    task automatic test_wrap();
        start_i = 1'b1; start_tid_i = 3'd6; start_pc_i = 32'hFFFF_FFFC;
        step();
        start_i = 1'b0;
        step();
        checks++;
        if (tid_f_o !== 3'd6 || pc_f_o !== 32'hFFFF_FFFC || pc_plus4_f_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap_issue got tid=%0d pc=%h p4=%h exp 6/fffffffc/0", tid_f_o, pc_f_o, pc_plus4_f_o);
        end
        step();
        step();
        checks++;
        if (tid_f_o !== 3'd6 || pc_f_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next got tid=%0d pc=%h exp 6/0", tid_f_o, pc_f_o);
        end
    endtask

    task automatic test_mid_reset();
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if (pc_f_o !== 32'h0 || pc_plus4_f_o !== 32'h0 || tid_f_o !== 3'd0 || valid_f_o !== 1'b0 || active_o !== 8'h01) begin
            failures++;
            $display("FAIL async_reset got pc=%h p4=%h tid=%0d v=%b act=%h exp 0/0/0/0/01", pc_f_o, pc_plus4_f_o, tid_f_o, valid_f_o, active_o);
        end
        @(negedge clk);
        clr_n = 1'b1;
        step();
        checks++;
        if (valid_f_o !== 1'b1 || tid_f_o !== 3'd0 || pc_f_o !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_issue got v=%b tid=%0d pc=%h exp 1/0/0", valid_f_o, tid_f_o, pc_f_o);
        end
        step();
        checks++;
        if (tid_f_o !== 3'd0 || pc_f_o !== 32'h4) begin
            failures++;
            $display("FAIL post_reset_second got tid=%0d pc=%h exp 0/4", tid_f_o, pc_f_o);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_thread();
        test_round_robin();
        test_stall();
        test_redirect();
        test_halt_start();
        test_same_edge();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, PC width.
REQ-002 Parameter BITS_THREADS, default 3, thread-ID width; NTHREADS = 2**BITS_THREADS.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, thread-0 PC after reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 clr_n  in  1  asynchronous, active-low reset.
REQ-006 stall_i  in  1  high = freeze issue (F/D register holding).
REQ-007 start_i, start_tid_i, start_pc_i  in  1/BITS_THREADS/ADDRESS_WIDTH  launch thread at PC.
REQ-008 halt_i, halt_tid_i  in  1/BITS_THREADS  park thread.
REQ-009 redir_i, redir_tid_i, redir_pc_i  in  1/BITS_THREADS/ADDRESS_WIDTH  taken branch/jump from execute.
REQ-010 pc_f_o, pc_plus4_f_o  out  ADDRESS_WIDTH each  issued PC and PC+4.
REQ-011 tid_f_o  out  BITS_THREADS  issued thread ID.
REQ-012 valid_f_o  out  1  outputs carry a real issue this cycle.
REQ-013 active_o  out  NTHREADS  per-thread RUN mask.

Function
REQ-014 Per-thread two-state FSM IDLE/RUN plus per-thread PC table entry.
REQ-015 IDLE->RUN on start_i for that tid: PC entry <= start_pc_i; RUN->IDLE on halt_i for that tid.
REQ-016 start_i or halt_i sampled at edge k takes effect after edge k; the thread is first eligible at edge k+1.
REQ-017 At each edge with stall_i low, select the first RUN thread strictly after the last issued tid, scanning upward modulo NTHREADS (round-robin).
REQ-018 If a thread is selected: pc_f_o <= its PC, pc_plus4_f_o <= PC+4, tid_f_o <= tid, valid_f_o <= 1, PC entry <= PC+4, last-issued pointer <= tid.
REQ-019 If no thread is in RUN: valid_f_o <= 0; pc/tid outputs and pointer hold.
REQ-020 stall_i high: no selection; all outputs and the pointer hold; start/halt/redirect still update FSM state and the PC table.
REQ-021 Redirect for a RUN thread: PC entry <= redir_pc_i; redirect for an IDLE thread is ignored.
REQ-022 Redirect and issue of the same tid at the same edge: issue uses redir_pc_i (bypass), entry <= redir_pc_i+4.
REQ-023 Start and halt of the same tid at the same edge: halt wins, thread stays/becomes IDLE, PC entry still loaded.
REQ-024 Halt of the thread being selected at that edge: the issue still occurs; the thread is excluded from the next edge onward.
REQ-025 PC arithmetic is modulo 2**ADDRESS_WIDTH; wrap from all-ones-minus-3 to 0 is legal.
REQ-026 Registered outputs only; one-cycle latency from selection edge to output.

Reset
REQ-027 On clr_n low (asynchronous): thread 0 RUN with PC = RESET_PC; all other threads IDLE with PC 0.
REQ-028 Reset values: pc_f_o 0, pc_plus4_f_o 0, tid_f_o 0, valid_f_o 0, active_o = 1, last-issued pointer = NTHREADS-1 (so thread 0 issues first).
REQ-029 Reset asserted mid-operation discards all pending state; the first edge after release issues thread 0 at RESET_PC.

Structure
REQ-030 Shared package holds BITS_THREADS, NTHREADS, ADDRESS_WIDTH and the IDLE/RUN encoding.
REQ-031 One sub-module, rr_pick: combinational round-robin selector (mask, last pointer -> tid, found).
REQ-032 The PC table is a flop array (NTHREADS x ADDRESS_WIDTH), not inferred RAM.

Verification
REQ-033 Reset release, no other input -> valid_f_o high every cycle, tid 0, pc 0,4,8,12...
REQ-034 Start tids 1, 2 at 0x100, 0x200 -> issue order 0,1,2,0,1,2; each thread's PC advances by 4 per issue.
REQ-035 stall_i high 3 cycles mid-stream -> outputs frozen 3 cycles, round-robin resumes at the next tid in order.
REQ-036 redir tid 1 to 0x400 on the edge tid 1 issues -> pc_f_o 0x400, next tid-1 issue 0x404.
REQ-037 Halt all threads -> valid_f_o low; start tid 5 at 0x80 -> tid 5 issued two edges later at 0x80.
REQ-038 start and halt tid 3 same edge -> active_o[3] stays 0; clr_n pulse mid-run -> state equals REQ-028.
